sc_fifo_csr_sequencer: RTL and testbench

//  Single-clock controller for the RX/TX sc_fifo CSR slaves. After reset it programs both FIFOs'

---
 rtl/sc_fifo_csr_pkg.sv | 33 +++
 rtl/sc_fifo_poll_timer.sv | 60 ++++++
 rtl/sc_fifo_csr_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_sc_fifo_csr_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_fifo_csr_pkg.sv
// ----------------------------------------------------------------------------
// sc_fifo_csr_pkg
//   Shared definitions for the sc_fifo CSR sequencer:
//   - CSR word addresses of the sc_fifo CSR slave
//   - sequencer FSM state encoding
//   - init-table entry layout {sel_tx, addr, data}
// ----------------------------------------------------------------------------
package sc_fifo_csr_pkg;

  localparam logic [2:0] CSR_FILL = 3'd0;
  localparam logic [2:0] CSR_AF   = 3'd2;
  localparam logic [2:0] CSR_AE   = 3'd3;
  localparam logic [2:0] CSR_CUT  = 3'd4;
  localparam logic [2:0] CSR_DROP = 3'd5;

  localparam int INIT_LEN = 7;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_POLL_RD,
    ST_HOST_WR,
    ST_HOST_RD,
    ST_RD_WAIT
  } state_e;

  typedef struct packed {
    logic        sel_tx;
    logic [2:0]  addr;
    logic [31:0] data;
  } init_entry_t;

endpackage

// File: rtl/sc_fifo_poll_timer.sv
// ----------------------------------------------------------------------------
// sc_fifo_poll_timer
//   16-bit down-counter that raises poll_due once every POLL_PERIOD cycles.
//   Ports:
//     clk_i   clock
//     rst_ni  synchronous reset, active low
//     en_i    count enable (high once init has completed)
//     load_i  load POLL_PERIOD-1 (pulsed when init completes)
//     clr_i   clear poll_due (pulsed when a poll round finishes)
//     due_o   poll_due flag
// ----------------------------------------------------------------------------
module sc_fifo_poll_timer
  import sc_fifo_csr_pkg::*;
#(
  parameter int unsigned POLL_PERIOD = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic load_i,
  input  logic clr_i,
  output logic due_o
);

  localparam logic [15:0] RELOAD = 16'(POLL_PERIOD - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        due_q, due_d;

  // An expiry while due is already set leaves it set: expiries do not queue.
  // An expiry in the same cycle as a clear wins, so it is not lost.
  always_comb begin
    cnt_d = cnt_q;
    due_d = due_q;
    if (clr_i) due_d = 1'b0;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      if (cnt_q == 16'd0) begin
        cnt_d = RELOAD;
        due_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      due_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      due_q <= due_d;
    end
  end

  assign due_o = due_q;

endmodule

// File: rtl/sc_fifo_csr_sequencer.sv
// ----------------------------------------------------------------------------
// sc_fifo_csr_sequencer
//   Programs the RX/TX sc_fifo CSR slaves after reset, then round-robins
//   periodic fill-level polls against host CSR accesses.
//   Ports:
//     clk_clk, clk_reset_reset_n      clock, synchronous active-low reset
//     host_*                          host CSR slave port (addr[3] selects TX)
//     rx_csr_*, tx_csr_*              master ports to the two sc_fifo CSRs
//     init_done                       init table has been written
//     rx_fill_level, tx_fill_level    last sampled fill levels
//     fill_update                     one-cycle pulse when both levels refresh
// ----------------------------------------------------------------------------
module sc_fifo_csr_sequencer
  import sc_fifo_csr_pkg::*;
#(
  parameter int unsigned RX_AF_THR   = 448,
  parameter int unsigned RX_AE_THR   = 16,
  parameter int unsigned RX_DROP_ERR = 1,
  parameter int unsigned TX_AF_THR   = 448,
  parameter int unsigned TX_AE_THR   = 16,
  parameter int unsigned TX_CUT_THR  = 0,
  parameter int unsigned POLL_PERIOD = 1024
) (
  input  logic        clk_clk,
  input  logic        clk_reset_reset_n,
  input  logic [3:0]  host_address,
  input  logic        host_read,
  input  logic        host_write,
  input  logic [31:0] host_writedata,
  output logic        host_waitrequest,
  output logic [31:0] host_readdata,
  output logic        host_readdatavalid,
  output logic [2:0]  rx_csr_address,
  output logic        rx_csr_read,
  output logic        rx_csr_write,
  output logic [31:0] rx_csr_writedata,
  input  logic [31:0] rx_csr_readdata,
  output logic [2:0]  tx_csr_address,
  output logic        tx_csr_read,
  output logic        tx_csr_write,
  output logic [31:0] tx_csr_writedata,
  input  logic [31:0] tx_csr_readdata,
  output logic        init_done,
  output logic [31:0] rx_fill_level,
  output logic [31:0] tx_fill_level,
  output logic        fill_update
);

  function automatic init_entry_t init_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    return '{sel_tx: 1'b0, addr: CSR_AF,   data: 32'(RX_AF_THR)};
      3'd1:    return '{sel_tx: 1'b0, addr: CSR_AE,   data: 32'(RX_AE_THR)};
      3'd2:    return '{sel_tx: 1'b0, addr: CSR_DROP, data: 32'(RX_DROP_ERR & 32'd1)};
      3'd3:    return '{sel_tx: 1'b1, addr: CSR_AF,   data: 32'(TX_AF_THR)};
      3'd4:    return '{sel_tx: 1'b1, addr: CSR_AE,   data: 32'(TX_AE_THR)};
      3'd5:    return '{sel_tx: 1'b1, addr: CSR_CUT,  data: 32'(TX_CUT_THR)};
      default: return '{sel_tx: 1'b1, addr: CSR_DROP, data: 32'd0};
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        init_done_q, init_done_d;
  logic        prio_host_q, prio_host_d;
  logic        rd_host_q, rd_host_d;
  logic        rd_tx_q, rd_tx_d;
  logic        poll_tx_q, poll_tx_d;
  logic [31:0] rx_tmp_q, rx_tmp_d;
  logic [31:0] rx_fill_q, rx_fill_d;
  logic [31:0] tx_fill_q, tx_fill_d;
  logic        fill_upd_q, fill_upd_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic        hrdv_q, hrdv_d;

  logic        bus_tx, bus_rd, bus_wr, waitreq;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata, rd_data;
  logic        host_req, poll_due, tmr_load, tmr_clr;
  init_entry_t entry;

  sc_fifo_poll_timer #(
    .POLL_PERIOD(POLL_PERIOD)
  ) u_timer (
    .clk_i (clk_clk),
    .rst_ni(clk_reset_reset_n),
    .en_i  (init_done_q),
    .load_i(tmr_load),
    .clr_i (tmr_clr),
    .due_o (poll_due)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    prio_host_d = prio_host_q;
    rd_host_d   = rd_host_q;
    rd_tx_d     = rd_tx_q;
    poll_tx_d   = poll_tx_q;
    rx_tmp_d    = rx_tmp_q;
    rx_fill_d   = rx_fill_q;
    tx_fill_d   = tx_fill_q;
    fill_upd_d  = 1'b0;
    hrdata_d    = hrdata_q;
    hrdv_d      = 1'b0;
    bus_tx      = 1'b0;
    bus_addr    = 3'd0;
    bus_rd      = 1'b0;
    bus_wr      = 1'b0;
    bus_wdata   = 32'd0;
    waitreq     = 1'b1;
    tmr_load    = 1'b0;
    tmr_clr     = 1'b0;
    entry       = init_entry(idx_q);
    host_req    = host_read | host_write;
    rd_data     = rd_tx_q ? tx_csr_readdata : rx_csr_readdata;

    case (state_q)
      ST_INIT: begin
        bus_tx    = entry.sel_tx;
        bus_addr  = entry.addr;
        bus_wr    = 1'b1;
        bus_wdata = entry.data;
        if (idx_q == 3'(INIT_LEN - 1)) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
          tmr_load    = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_IDLE: begin
        // With both pending the pointer decides; the winner hands priority over.
        if (poll_due && (!host_req || !prio_host_q)) begin
          state_d     = ST_POLL_RD;
          poll_tx_d   = 1'b0;
          prio_host_d = 1'b1;
        end else if (host_req) begin
          state_d     = host_write ? ST_HOST_WR : ST_HOST_RD;
          prio_host_d = 1'b0;
        end
      end
      ST_POLL_RD: begin
        bus_tx    = poll_tx_q;
        bus_addr  = CSR_FILL;
        bus_rd    = 1'b1;
        rd_host_d = 1'b0;
        rd_tx_d   = poll_tx_q;
        state_d   = ST_RD_WAIT;
      end
      ST_HOST_WR: begin
        waitreq   = 1'b0;
        bus_tx    = host_address[3];
        bus_addr  = host_address[2:0];
        bus_wr    = 1'b1;
        bus_wdata = host_writedata;
        state_d   = ST_IDLE;
      end
      ST_HOST_RD: begin
        waitreq   = 1'b0;
        bus_tx    = host_address[3];
        bus_addr  = host_address[2:0];
        bus_rd    = 1'b1;
        rd_host_d = 1'b1;
        rd_tx_d   = host_address[3];
        state_d   = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (rd_host_q) begin
          hrdata_d = rd_data;
          hrdv_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (!poll_tx_q) begin
          // Hold the RX sample so both levels publish together after the TX read.
          rx_tmp_d  = rd_data;
          poll_tx_d = 1'b1;
          state_d   = ST_POLL_RD;
        end else begin
          rx_fill_d  = rx_tmp_q;
          tx_fill_d  = rd_data;
          fill_upd_d = 1'b1;
          tmr_clr    = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Keep both CSR buses quiet and the host stalled while reset is held.
    if (!clk_reset_reset_n) begin
      bus_tx    = 1'b0;
      bus_addr  = 3'd0;
      bus_rd    = 1'b0;
      bus_wr    = 1'b0;
      bus_wdata = 32'd0;
      waitreq   = 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!clk_reset_reset_n) begin
      state_q     <= ST_INIT;
      idx_q       <= 3'd0;
      init_done_q <= 1'b0;
      prio_host_q <= 1'b0;
      rd_host_q   <= 1'b0;
      rd_tx_q     <= 1'b0;
      poll_tx_q   <= 1'b0;
      rx_fill_q   <= 32'd0;
      tx_fill_q   <= 32'd0;
      fill_upd_q  <= 1'b0;
      hrdata_q    <= 32'd0;
      hrdv_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      prio_host_q <= prio_host_d;
      rd_host_q   <= rd_host_d;
      rd_tx_q     <= rd_tx_d;
      poll_tx_q   <= poll_tx_d;
      rx_fill_q   <= rx_fill_d;
      tx_fill_q   <= tx_fill_d;
      fill_upd_q  <= fill_upd_d;
      hrdata_q    <= hrdata_d;
      hrdv_q      <= hrdv_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    rx_tmp_q <= rx_tmp_d;
  end

  assign rx_csr_address   = bus_tx ? 3'd0  : bus_addr;
  assign rx_csr_read      = !bus_tx && bus_rd;
  assign rx_csr_write     = !bus_tx && bus_wr;
  assign rx_csr_writedata = bus_tx ? 32'd0 : bus_wdata;
  assign tx_csr_address   = bus_tx ? bus_addr  : 3'd0;
  assign tx_csr_read      = bus_tx && bus_rd;
  assign tx_csr_write     = bus_tx && bus_wr;
  assign tx_csr_writedata = bus_tx ? bus_wdata : 32'd0;

  assign host_waitrequest   = waitreq;
  assign host_readdata      = hrdata_q;
  assign host_readdatavalid = hrdv_q;
  assign init_done          = init_done_q;
  assign rx_fill_level      = rx_fill_q;
  assign tx_fill_level      = tx_fill_q;
  assign fill_update        = fill_upd_q;

endmodule

// File: tb/tb_sc_fifo_csr_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sc_fifo_csr_sequencer
//   Directed bench: init table, host read, periodic polls, host/poll
//   arbitration, reset during a host read, host request during init.
// ----------------------------------------------------------------------------
module tb_sc_fifo_csr_sequencer;

  typedef struct {
    int          cyc;
    logic        tx;
    logic [2:0]  addr;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    int          cyc;
    logic [31:0] rx;
    logic [31:0] tx;
  } fu_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  host_address;
  logic        host_read, host_write;
  logic [31:0] host_writedata;
  logic        host_waitrequest;
  logic [31:0] host_readdata;
  logic        host_readdatavalid;
  logic [2:0]  rx_csr_address, tx_csr_address;
  logic        rx_csr_read, rx_csr_write, tx_csr_read, tx_csr_write;
  logic [31:0] rx_csr_writedata, tx_csr_writedata;
  logic [31:0] rx_csr_readdata, tx_csr_readdata;
  logic        init_done;
  logic [31:0] rx_fill_level, tx_fill_level;
  logic        fill_update;

  logic [31:0] rx_val, tx_val;

  int n_tests = 0;
  int n_fail  = 0;

  int   cyc = 0;
  int   viol = 0;
  int   ibv = 0;
  int   id_cyc = -1;
  logic id_prev = 1'b0;
  ev_t  wlog[$];
  ev_t  rlog[$];
  ev_t  rdv_log[$];
  fu_t  fu_log[$];
  int   wq_log[$];

  logic [3:0]  exp_sel[7];
  logic [31:0] exp_dat[7];

  int   w0, r0, f0, q0, d0, wbase, g, n, end_cyc, rc;
  int   npairs, nsplit, nfollow, nbadwr;
  logic found, paired;
  logic [3:0] sel;

  sc_fifo_csr_sequencer #(
    .POLL_PERIOD(16)
  ) dut (
    .clk_clk           (clk),
    .clk_reset_reset_n (rst_n),
    .host_address      (host_address),
    .host_read         (host_read),
    .host_write        (host_write),
    .host_writedata    (host_writedata),
    .host_waitrequest  (host_waitrequest),
    .host_readdata     (host_readdata),
    .host_readdatavalid(host_readdatavalid),
    .rx_csr_address    (rx_csr_address),
    .rx_csr_read       (rx_csr_read),
    .rx_csr_write      (rx_csr_write),
    .rx_csr_writedata  (rx_csr_writedata),
    .rx_csr_readdata   (rx_csr_readdata),
    .tx_csr_address    (tx_csr_address),
    .tx_csr_read       (tx_csr_read),
    .tx_csr_write      (tx_csr_write),
    .tx_csr_writedata  (tx_csr_writedata),
    .tx_csr_readdata   (tx_csr_readdata),
    .init_done         (init_done),
    .rx_fill_level     (rx_fill_level),
    .tx_fill_level     (tx_fill_level),
    .fill_update       (fill_update)
  );

  always #5 clk = ~clk;

  // Latency-1 CSR slave stubs; junk when not read so wrong-cycle sampling shows.
  always @(posedge clk) begin
    rx_csr_readdata <= rx_csr_read ? rx_val : 32'hBAD0_0001;
    tx_csr_readdata <= tx_csr_read ? tx_val : 32'hBAD0_0002;
  end

  // Bus/event recorder: each entry is labelled with the cycle ending at this edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_csr_write) wlog.push_back('{cyc, 1'b0, rx_csr_address, rx_csr_writedata});
    if (tx_csr_write) wlog.push_back('{cyc, 1'b1, tx_csr_address, tx_csr_writedata});
    if (rx_csr_read)  rlog.push_back('{cyc, 1'b0, rx_csr_address, 32'd0});
    if (tx_csr_read)  rlog.push_back('{cyc, 1'b1, tx_csr_address, 32'd0});
    if (host_readdatavalid) rdv_log.push_back('{cyc, 1'b0, 3'd0, host_readdata});
    if (fill_update) fu_log.push_back('{cyc, rx_fill_level, tx_fill_level});
    if (!host_waitrequest) wq_log.push_back(cyc);
    if ($countones({rx_csr_read, rx_csr_write, tx_csr_read, tx_csr_write}) > 1) viol <= viol + 1;
    if ((!rx_csr_read && !rx_csr_write && (rx_csr_address != 3'd0 || rx_csr_writedata != 32'd0)) ||
        (!tx_csr_read && !tx_csr_write && (tx_csr_address != 3'd0 || tx_csr_writedata != 32'd0)))
      ibv <= ibv + 1;
    if (init_done && !id_prev) id_cyc <= cyc;
    id_prev <= init_done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic host_access(input logic wr, input logic [3:0] a, input logic [31:0] d);
    int k;
    @(negedge clk);
    host_address   = a;
    host_writedata = d;
    host_write     = wr;
    host_read      = !wr;
    k = 0;
    while (host_waitrequest && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("host_grant_timeout", 1, 0);
    @(negedge clk);
    host_read  = 1'b0;
    host_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_sel = '{4'h2, 4'h3, 4'h5, 4'hA, 4'hB, 4'hC, 4'hD};
    exp_dat = '{32'd448, 32'd16, 32'd1, 32'd448, 32'd16, 32'd0, 32'd0};
    rst_n = 1'b0;
    host_address = 4'h0;
    host_read = 1'b0;
    host_write = 1'b0;
    host_writedata = 32'd0;
    rx_val = 32'd37;
    tx_val = 32'd5;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_waitreq", 32'(host_waitrequest), 1);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_strobes", 32'({rx_csr_read, rx_csr_write, tx_csr_read, tx_csr_write}), 0);
    check("rst_rdv", 32'(host_readdatavalid), 0);
    check("rst_fill_update", 32'(fill_update), 0);

    // Init table, then periodic polls with RX=37, TX=5
    w0 = wlog.size(); r0 = rlog.size(); f0 = fu_log.size();
    rst_n = 1'b1;
    repeat (70) @(negedge clk);
    check("init_nwr", 32'(wlog.size() - w0), 7);
    if (wlog.size() - w0 >= 7) begin
      for (int i = 0; i < 7; i++) begin
        check($sformatf("init_sel%0d", i), 32'({wlog[w0+i].tx, wlog[w0+i].addr}), 32'(exp_sel[i]));
        check($sformatf("init_dat%0d", i), wlog[w0+i].data, exp_dat[i]);
        check($sformatf("init_cyc%0d", i), 32'(wlog[w0+i].cyc - wlog[w0].cyc), 32'(i));
      end
      wbase = wlog[w0+6].cyc;
      check("init_done_rise", 32'(id_cyc), 32'(wbase + 1));
      check("poll_nrd", 32'(rlog.size() - r0 >= 2), 1);
      if (rlog.size() - r0 >= 2) begin
        check("poll_rx_rd", 32'({rlog[r0].tx, rlog[r0].addr}), 32'h0);
        check("poll_rx_cyc", 32'(rlog[r0].cyc), 32'(wbase + 18));
        check("poll_tx_rd", 32'({rlog[r0+1].tx, rlog[r0+1].addr}), 32'h8);
        check("poll_tx_cyc", 32'(rlog[r0+1].cyc), 32'(wbase + 20));
      end
      check("poll_nfu", 32'(fu_log.size() - f0 >= 3), 1);
      if (fu_log.size() - f0 >= 3) begin
        check("poll_fu_cyc", 32'(fu_log[f0].cyc), 32'(wbase + 22));
        check("poll_period", 32'(fu_log[f0+1].cyc - fu_log[f0].cyc), 16);
        check("poll_period2", 32'(fu_log[f0+2].cyc - fu_log[f0+1].cyc), 16);
        check("poll_rx_level", fu_log[f0].rx, 32'd37);
        check("poll_tx_level", fu_log[f0].tx, 32'd5);
      end
    end
    check("init_done_high", 32'(init_done), 1);
    check("rx_fill_out", rx_fill_level, 32'd37);

    // Host read of TX addr 2, stub returns 448
    tx_val = 32'd448;
    r0 = rlog.size(); q0 = wq_log.size(); d0 = rdv_log.size();
    host_access(1'b0, 4'hA, 32'd0);
    repeat (6) @(negedge clk);
    check("hrd_nwait_low", 32'(wq_log.size() - q0), 1);
    check("hrd_nrdv", 32'(rdv_log.size() - d0), 1);
    if (wq_log.size() - q0 >= 1 && rdv_log.size() - d0 >= 1) begin
      g = wq_log[q0];
      check("hrd_latency", 32'(rdv_log[d0].cyc - g), 2);
      check("hrd_data", rdv_log[d0].data, 32'd448);
      sel = 4'h0;
      for (int i = r0; i < rlog.size(); i++)
        if (rlog[i].cyc == g) sel = {rlog[i].tx, rlog[i].addr};
      check("hrd_bus_addr", 32'(sel), 32'hA);
    end

    // Host write held continuously across poll rounds
    w0 = wlog.size(); r0 = rlog.size();
    @(negedge clk);
    host_address   = 4'h1;
    host_writedata = 32'h1234;
    host_write     = 1'b1;
    repeat (40) @(negedge clk);
    host_write = 1'b0;
    end_cyc = cyc;
    repeat (8) @(negedge clk);
    npairs = 0; nsplit = 0; nfollow = 0; nbadwr = 0;
    for (int i = r0; i < rlog.size(); i++) begin
      if (!rlog[i].tx && rlog[i].addr == 3'd0 && rlog[i].cyc < end_cyc) begin
        rc = rlog[i].cyc;
        paired = 1'b0;
        for (int j = r0; j < rlog.size(); j++)
          if (rlog[j].tx && rlog[j].addr == 3'd0 && rlog[j].cyc == rc + 2) paired = 1'b1;
        if (paired) npairs++;
        found = 1'b0;
        for (int k = w0; k < wlog.size(); k++) begin
          if (wlog[k].cyc >= rc + 1 && wlog[k].cyc <= rc + 3) nsplit++;
          if (wlog[k].cyc == rc + 5) found = 1'b1;
        end
        if (rc + 5 < end_cyc && !found) nfollow++;
      end
    end
    for (int k = w0; k < wlog.size(); k++)
      if (wlog[k].tx || wlog[k].addr != 3'd1 || wlog[k].data != 32'h1234) nbadwr++;
    check("arb_polls", 32'(npairs >= 2), 1);
    check("arb_split", 32'(nsplit), 0);
    check("arb_host_after_poll", 32'(nfollow), 0);
    check("arb_host_wr_data", 32'(nbadwr), 0);
    check("arb_nhost_wr", 32'(wlog.size() - w0 >= 10), 1);

    // Reset during HOST_RD, with a host write then pending across init
    w0 = wlog.size(); d0 = rdv_log.size(); q0 = wq_log.size();
    @(negedge clk);
    host_address = 4'hA;
    host_read    = 1'b1;
    n = 0;
    while (host_waitrequest && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("rstrd_grant_timeout", 1, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rstrd_waitreq", 32'(host_waitrequest), 1);
    check("rstrd_rdv", 32'(host_readdatavalid), 0);
    check("rstrd_rdata", host_readdata, 32'd0);
    check("rstrd_init_done", 32'(init_done), 0);
    check("rstrd_rx_fill", rx_fill_level, 32'd0);
    check("rstrd_tx_fill", tx_fill_level, 32'd0);
    check("rstrd_strobes", 32'({rx_csr_read, rx_csr_write, tx_csr_read, tx_csr_write}), 0);
    host_read      = 1'b0;
    host_address   = 4'h9;
    host_writedata = 32'h55;
    host_write     = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (host_waitrequest && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("init_host_timeout", 1, 0);
    @(negedge clk);
    host_write = 1'b0;
    repeat (5) @(negedge clk);
    check("rstrd_no_rdv", 32'(rdv_log.size() - d0), 0);
    check("reinit_nwr", 32'(wlog.size() - w0), 8);
    if (wlog.size() - w0 >= 8) begin
      for (int i = 0; i < 7; i++) begin
        check($sformatf("reinit_sel%0d", i), 32'({wlog[w0+i].tx, wlog[w0+i].addr}), 32'(exp_sel[i]));
        check($sformatf("reinit_dat%0d", i), wlog[w0+i].data, exp_dat[i]);
      end
      wbase = wlog[w0+6].cyc;
      check("reinit_done_rise", 32'(id_cyc), 32'(wbase + 1));
      check("init_host_wr_sel", 32'({wlog[w0+7].tx, wlog[w0+7].addr}), 32'h9);
      check("init_host_wr_dat", wlog[w0+7].data, 32'h55);
      check("init_host_wr_cyc", 32'(wlog[w0+7].cyc), 32'(wbase + 2));
      if (wq_log.size() - q0 >= 1)
        check("init_host_grant", 32'(wq_log[q0]), 32'(wbase + 2));
      else
        check("init_host_grant", 0, 32'(wbase + 2));
    end

    check("one_strobe", 32'(viol), 0);
    check("idle_bus_zero", 32'(ibv), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
